// File: rtl/cle_pkg.sv
// Shared constants, state encoding and pixel-index helpers for the
// connected-component labeling read-back path.
package cle_pkg;
    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int LBL_W  = 8;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NBYTES = NPIX / 8;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int BYTE_W = $clog2(NBYTES);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // IMG_W is a power of two, so row/column are plain bit fields of the index.
    function automatic logic [ROW_W-1:0] pix_row(input logic [ADDR_W-1:0] idx);
        return idx[ADDR_W-1:COL_W];
    endfunction

    function automatic logic [COL_W-1:0] pix_col(input logic [ADDR_W-1:0] idx);
        return idx[COL_W-1:0];
    endfunction
endpackage

// File: rtl/cle_bbox_acc.sv
// Pixel counter and bounding-box accumulator; clear resets to the empty
// sentinel (min=max_index, max=0), each hit folds one pixel index in.
module cle_bbox_acc
    import cle_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              hit,
    input  logic [ADDR_W-1:0] pix_idx,
    output logic [CNT_W-1:0]  pix_cnt,
    output logic [ROW_W-1:0]  row_min,
    output logic [ROW_W-1:0]  row_max,
    output logic [COL_W-1:0]  col_min,
    output logic [COL_W-1:0]  col_max
);
    localparam logic [ROW_W-1:0] ROW_TOP = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TOP = COL_W'(IMG_W - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_min_q, row_min_d, row_max_q, row_max_d;
    logic [COL_W-1:0] col_min_q, col_min_d, col_max_q, col_max_d;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    always_comb begin
        row       = pix_row(pix_idx);
        col       = pix_col(pix_idx);
        cnt_d     = cnt_q;
        row_min_d = row_min_q;
        row_max_d = row_max_q;
        col_min_d = col_min_q;
        col_max_d = col_max_q;
        if (clear) begin
            cnt_d     = '0;
            row_min_d = ROW_TOP;
            row_max_d = '0;
            col_min_d = COL_TOP;
            col_max_d = '0;
        end else if (hit) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (row < row_min_q) row_min_d = row;
            if (row > row_max_q) row_max_d = row;
            if (col < col_min_q) col_min_d = col;
            if (col > col_max_q) col_max_d = col;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            row_min_q <= ROW_TOP;
            row_max_q <= '0;
            col_min_q <= COL_TOP;
            col_max_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            row_min_q <= row_min_d;
            row_max_q <= row_max_d;
            col_min_q <= col_min_d;
            col_max_q <= col_max_d;
        end
    end

    assign pix_cnt = cnt_q;
    assign row_min = row_min_q;
    assign row_max = row_max_q;
    assign col_min = col_min_q;
    assign col_max = col_max_q;
endmodule

// File: rtl/cle_label_reader.sv
// Scans the label SRAM for one label and streams the 1-bit/pixel mask as
// 128 bytes (LSB = lowest pixel), plus pixel count and bounding box.
module cle_label_reader
    import cle_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LBL_W-1:0]  label,
    output logic [ADDR_W-1:0] sram_a,
    input  logic [LBL_W-1:0]  sram_q,
    output logic [7:0]        m_data,
    output logic [BYTE_W-1:0] m_addr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pix_cnt,
    output logic [ROW_W-1:0]  row_min,
    output logic [ROW_W-1:0]  row_max,
    output logic [COL_W-1:0]  col_min,
    output logic [COL_W-1:0]  col_max
);
    // Stream handshake: m_data/m_addr are held stable while m_valid=1 and
    // m_ready=0; a byte transfers on a rising edge with m_valid && m_ready.
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] k_q, k_d;
    logic [3:0]        j_q, j_d;
    logic [LBL_W-1:0]  lbl_q, lbl_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [ADDR_W-1:0] sram_a_q, sram_a_d;
    logic [7:0]        m_data_q, m_data_d;
    logic [BYTE_W-1:0] m_addr_q, m_addr_d;
    logic              m_valid_q, m_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              acc_clear;
    logic              acc_hit;
    logic [2:0]        bit_sel;
    logic [2:0]        next_j_lo;
    logic [ADDR_W-1:0] pix_idx;
    logic              match;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        j_d       = j_q;
        lbl_d     = lbl_q;
        shreg_d   = shreg_q;
        sram_a_d  = sram_a_q;
        m_data_d  = m_data_q;
        m_addr_d  = m_addr_q;
        m_valid_d = m_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        acc_clear = 1'b0;
        acc_hit   = 1'b0;
        // sram_q during sub-step j holds entry 8k+j-1; wraps to bit 7 at j=8.
        bit_sel   = j_q[2:0] - 3'd1;
        next_j_lo = j_q[2:0] + 3'd1;
        pix_idx   = {k_q, bit_sel};
        match     = (sram_q == lbl_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lbl_d     = label;
                    k_d       = '0;
                    j_d       = '0;
                    shreg_d   = '0;
                    sram_a_d  = '0;
                    acc_clear = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (j_q != 4'd0) begin
                    shreg_d[bit_sel] = match;
                    acc_hit          = match;
                end
                if (j_q == 4'd8) begin
                    m_data_d  = shreg_d;
                    m_addr_d  = k_q;
                    m_valid_d = 1'b1;
                    state_d   = S_EMIT;
                end else begin
                    j_d = j_q + 4'd1;
                    if (j_q < 4'd7) sram_a_d = {k_q, next_j_lo};
                end
            end
            S_EMIT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (k_q == LAST_BYTE) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        k_d      = k_q + BYTE_W'(1);
                        j_d      = '0;
                        sram_a_d = {k_q + BYTE_W'(1), 3'd0};
                        state_d  = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            j_q       <= '0;
            lbl_q     <= '0;
            shreg_q   <= '0;
            sram_a_q  <= '0;
            m_data_q  <= '0;
            m_addr_q  <= '0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            j_q       <= j_d;
            lbl_q     <= lbl_d;
            shreg_q   <= shreg_d;
            sram_a_q  <= sram_a_d;
            m_data_q  <= m_data_d;
            m_addr_q  <= m_addr_d;
            m_valid_q <= m_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    cle_bbox_acc u_bbox (
        .clk     (clk),
        .reset   (reset),
        .clear   (acc_clear),
        .hit     (acc_hit),
        .pix_idx (pix_idx),
        .pix_cnt (pix_cnt),
        .row_min (row_min),
        .row_max (row_max),
        .col_min (col_min),
        .col_max (col_max)
    );

    assign sram_a  = sram_a_q;
    assign m_data  = m_data_q;
    assign m_addr  = m_addr_q;
    assign m_valid = m_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_cle_label_reader.sv
// Directed bench for cle_label_reader: SRAM model, expected-byte queue with
// an independent stream monitor, latency and statistics checks per scan.
module tb_cle_label_reader;
    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  label;
    logic [9:0]  sram_a;
    logic [7:0]  sram_q;
    logic [7:0]  m_data;
    logic [6:0]  m_addr;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic [10:0] pix_cnt;
    logic [4:0]  row_min, row_max, col_min, col_max;

    logic [7:0]  mem [1024];
    logic [14:0] exp_q [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_seen = 0;
    int done_cyc = 0;
    int first_valid = -1;
    bit rnd_ready = 0;
    bit stalled = 0;
    logic [7:0] hold_data;
    logic [6:0] hold_addr;

    cle_label_reader dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .label   (label),
        .sram_a  (sram_a),
        .sram_q  (sram_q),
        .m_data  (m_data),
        .m_addr  (m_addr),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .busy    (busy),
        .done    (done),
        .pix_cnt (pix_cnt),
        .row_min (row_min),
        .row_max (row_max),
        .col_min (col_min),
        .col_max (col_max)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // label SRAM: one-cycle read latency
    always @(posedge clk) sram_q <= mem[sram_a];

    // downstream ready driver
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
            else           m_ready = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (stalled && m_valid) begin
                check("hold_data", 32'(m_data), 32'(hold_data));
                check("hold_addr", 32'(m_addr), 32'(hold_addr));
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stream_extra act=%0d/%0h exp=none", m_addr, m_data);
                end else begin
                    check("stream", 32'({m_addr, m_data}), 32'(exp_q.pop_front()));
                end
            end
            stalled   = m_valid && !m_ready;
            hold_data = m_data;
            hold_addr = m_addr;
            if (done) begin
                done_seen++;
                done_cyc = cyc;
                check("done_busy_low", 32'(busy), 32'd0);
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic clear_mem();
        for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
    endtask

    // hand-filled expectation: every byte = fill, except byte sk = sv
    task automatic push_fill(input logic [7:0] fill, input int sk, input logic [7:0] sv);
        for (int k = 0; k < 128; k++) exp_q.push_back({7'(k), (k == sk) ? sv : fill});
    endtask

    // golden mask model built from the SRAM image
    task automatic push_model(input logic [7:0] lbl);
        logic [7:0] b;
        for (int k = 0; k < 128; k++) begin
            b = 8'd0;
            for (int i = 0; i < 8; i++) b[i] = (mem[8*k+i] == lbl);
            exp_q.push_back({7'(k), b});
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sram_a"},  32'(sram_a),  32'd0);
        check({tag, "_m_data"},  32'(m_data),  32'd0);
        check({tag, "_m_addr"},  32'(m_addr),  32'd0);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_pix_cnt"}, 32'(pix_cnt), 32'd0);
        check({tag, "_row_min"}, 32'(row_min), 32'd31);
        check({tag, "_row_max"}, 32'(row_max), 32'd0);
        check({tag, "_col_min"}, 32'(col_min), 32'd31);
        check({tag, "_col_max"}, 32'(col_max), 32'd0);
    endtask

    // driver: issue one scan and wait for done; expectations must be queued
    task automatic run_scan(input string tag, input logic [7:0] lbl, input bit perturb,
                            input int e_cnt, input int e_rmin, input int e_rmax,
                            input int e_cmin, input int e_cmax);
        int start_cyc;
        int d0;
        @(negedge clk);
        start = 1'b1;
        label = lbl;
        start_cyc = cyc;
        first_valid = -1;
        d0 = done_seen;
        @(negedge clk);
        start = 1'b0;
        label = 8'($urandom_range(0, 255));
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        for (int i = 0; i < 20000 && done_seen == d0; i++) begin
            @(negedge clk);
            if (perturb && cyc == start_cyc + 500) begin
                start = 1'b1;
                label = 8'd9;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
        if (!rnd_ready) begin
            check({tag, "_first_valid_lat"}, 32'(first_valid - start_cyc), 32'd10);
            check({tag, "_done_lat"}, 32'(done_cyc - start_cyc), 32'd1281);
        end
        check({tag, "_pix_cnt"}, 32'(pix_cnt), 32'(e_cnt));
        check({tag, "_row_min"}, 32'(row_min), 32'(e_rmin));
        check({tag, "_row_max"}, 32'(row_max), 32'(e_rmax));
        check({tag, "_col_min"}, 32'(col_min), 32'(e_cmin));
        check({tag, "_col_max"}, 32'(col_max), 32'(e_cmax));
        check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_pix_cnt_stable"}, 32'(pix_cnt), 32'(e_cnt));
    endtask

    // driver: start a scan, hit reset while byte 60 is presented
    task automatic run_reset_abort(input logic [7:0] lbl);
        bit seen;
        seen = 1'b0;
        push_model(lbl);
        @(negedge clk);
        start = 1'b1;
        label = lbl;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (m_valid && m_addr == 7'd60) seen = 1'b1;
        end
        check("abort_reached_byte60", 32'(seen), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("abort");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        label = 8'd0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;

        // 1: background mask of an all-zero image
        rnd_ready = 0;
        push_fill(8'hFF, -1, 8'h00);
        run_scan("t1", 8'd0, 0, 1024, 0, 31, 0, 31);

        // 2: single pixel at address 33 (row 1, col 1)
        mem[33] = 8'd5;
        push_fill(8'h00, 4, 8'h02);
        run_scan("t2", 8'd5, 0, 1, 1, 1, 1, 1);

        // 3: absent label leaves the empty sentinel
        push_fill(8'h00, -1, 8'h00);
        run_scan("t3", 8'd7, 0, 0, 31, 0, 31, 0);

        // 4: block straddling the right edge and wrapping to col 0, random ready
        clear_mem();
        mem[350] = 8'd2; mem[351] = 8'd2;
        mem[382] = 8'd2; mem[383] = 8'd2;
        mem[414] = 8'd2; mem[415] = 8'd2;
        mem[352] = 8'd2; mem[384] = 8'd2; mem[416] = 8'd2;
        mem[100] = 8'd3;
        rnd_ready = 1;
        push_model(8'd2);
        run_scan("t4", 8'd2, 0, 9, 10, 13, 0, 31);
        rnd_ready = 0;

        // 5: start with label 9 while busy must be ignored
        push_model(8'd2);
        run_scan("t5", 8'd2, 1, 9, 10, 13, 0, 31);

        // 6: reset mid-stream, then a fresh complete scan
        run_reset_abort(8'd2);
        push_model(8'd2);
        run_scan("t6", 8'd2, 0, 9, 10, 13, 0, 31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
